// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: divides clk_ref into BCLK/WS, double-buffers one stereo
// frame behind a valid/ready handshake, shifts it out MSB-first with WS leading
// each slot's MSB by one BCLK.
module i2s_tx_serializer #(
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned HALF_DIV = 24
) (
  input  logic                clk_ref,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                i2s_bclk,
  output logic                i2s_ws,
  output logic                i2s_sd,
  output logic                frame_start,
  output logic                underrun
);

  localparam int unsigned FRAME_W = 2 * SAMPLE_W;
  localparam int unsigned DIV_W   = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] WS_LO    = BIT_W'(SAMPLE_W - 1);
  localparam logic [BIT_W-1:0] WS_HI    = BIT_W'(FRAME_W - 2);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                bclk_q, bclk_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]  shift_q, shift_d;
  logic                sd_q, sd_d;
  logic                ws_q, ws_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
  logic                hold_full_q, hold_full_d;
  logic                ready_q, ready_d;
  logic                frame_start_q, frame_start_d;
  logic                underrun_q, underrun_d;

  logic tick;
  logic fall;
  logic accept;
  logic load;

  // Next-state: divider, fall-edge bit sequencing, frame load and hold handshake
  always_comb begin
    div_cnt_d     = div_cnt_q + 1'b1;
    bclk_d        = bclk_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    sd_d          = sd_q;
    ws_d          = ws_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    load          = 1'b0;

    tick   = (div_cnt_q == DIV_LAST);
    fall   = tick && bclk_q;
    accept = sample_valid && ready_q;

    if (tick) begin
      div_cnt_d = '0;
      bclk_d    = !bclk_q;
    end

    if (fall) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
      if (bit_cnt_d == '0) begin
        load    = 1'b1;
        shift_d = hold_full_q ? {hold_l_q, hold_r_q} : '0;
      end else begin
        shift_d = shift_q << 1;
      end
      sd_d = shift_d[FRAME_W-1];
      ws_d = (bit_cnt_d >= WS_LO) && (bit_cnt_d <= WS_HI);
    end

    // A frame accepted in the same cycle as a load (hold empty) is not
    // bypassed: the load takes zeros and the new data waits a full frame.
    if (accept) begin
      hold_l_d = sample_l;
      hold_r_d = sample_r;
    end
    hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);

    ready_d       = !hold_full_d;
    frame_start_d = load;
    underrun_d    = load && !hold_full_q;
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk_ref) begin
    if (!reset_n) begin
      div_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      bit_cnt_q     <= BIT_LAST;
      shift_q       <= '0;
      sd_q          <= 1'b0;
      ws_q          <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      hold_full_q   <= 1'b0;
      ready_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      sd_q          <= sd_d;
      ws_q          <= ws_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      hold_full_q   <= hold_full_d;
      ready_q       <= ready_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sample_ready = ready_q;
  assign i2s_bclk     = bclk_q;
  assign i2s_ws       = ws_q;
  assign i2s_sd       = sd_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: randomized frames through the handshake,
// a timeline model of the I2S frame derived from cycle arithmetic, and a
// scoreboard queue of accepted frames consumed at each expected load.
module tb_i2s_tx_serializer;

  localparam int W     = 24;
  localparam int H     = 24;
  localparam int FW    = 2 * W;
  localparam int FRAME = 4 * W * H;
  localparam int FIRST = 2 * H;

  typedef struct {
    int          cyc;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } ent_t;

  logic         clk_ref = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sample_l = '0;
  logic [W-1:0] sample_r = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready, i2s_bclk, i2s_ws, i2s_sd, frame_start, underrun;

  int checks = 0;
  int errors = 0;
  int c = -1;
  ent_t q[$];

  i2s_tx_serializer #(.SAMPLE_W(W), .HALF_DIV(H)) dut (
    .clk_ref      (clk_ref),
    .reset_n      (reset_n),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_ws       (i2s_ws),
    .i2s_sd       (i2s_sd),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clk_ref = ~clk_ref;

  // Cycles since reset release: 0 while in reset, 1 at the first free-running edge
  always @(posedge clk_ref) begin
    if (!reset_n) c <= 0;
    else if (c >= 0) c <= c + 1;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, c, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  // Expected WS across the 48 bit slots of a frame, from the slot rule
  logic [FW-1:0] ws_pat;
  initial begin
    ws_pat = '0;
    for (int i = 0; i < FW; i++) ws_pat[i] = (i >= W - 1) && (i <= FW - 2);
  end

  // Monitor: compares outputs against the cycle-arithmetic timeline and scoreboard
  logic [FW-1:0] exp_word, got_word, got_ws;
  bit            in_frame = 0;
  int            k = 0;
  always @(negedge clk_ref) begin
    logic fs_exp, ur_exp;
    ent_t e;
    if (c == 0) begin
      chk1("rst_bclk", i2s_bclk, 1'b0);
      chk1("rst_ws", i2s_ws, 1'b0);
      chk1("rst_sd", i2s_sd, 1'b0);
      chk1("rst_frame_start", frame_start, 1'b0);
      chk1("rst_underrun", underrun, 1'b0);
      chk1("rst_ready", sample_ready, 1'b0);
      in_frame = 0;
      k = 0;
    end else if (c > 0) begin
      chk1("bclk", i2s_bclk, ((c / H) % 2) == 1);
      fs_exp = (c >= FIRST) && (((c - FIRST) % FRAME) == 0);
      chk1("frame_start", frame_start, fs_exp);
      if (fs_exp) begin
        if (q.size() > 0 && q[0].cyc < c) begin
          e = q.pop_front();
          exp_word = {e.l, e.r};
          ur_exp = 1'b0;
        end else begin
          exp_word = '0;
          ur_exp = 1'b1;
        end
        chk1("underrun_at_load", underrun, ur_exp);
        in_frame = 1;
        k = 0;
        got_word = '0;
        got_ws = '0;
      end else begin
        chk1("underrun_idle", underrun, 1'b0);
      end
      if (c >= H && (c % (2 * H)) == H) begin
        if (in_frame) begin
          got_word[FW-1-k] = i2s_sd;
          got_ws[k] = i2s_ws;
          k++;
          if (k == FW) begin
            chkw("frame_data", got_word, exp_word);
            chkw("ws_pattern", got_ws, ws_pat);
            in_frame = 0;
          end
        end else begin
          chk1("preframe_sd", i2s_sd, 1'b0);
          chk1("preframe_ws", i2s_ws, 1'b0);
        end
      end
      chk1("ready", sample_ready, q.size() == 0);
    end
  end

  task automatic offer(input logic [W-1:0] l, input logic [W-1:0] r);
    int n;
    int acc;
    n = 0;
    @(negedge clk_ref);
    sample_l = l;
    sample_r = r;
    sample_valid = 1'b1;
    forever begin
      #1;
      if (sample_ready) begin
        acc = c + 1;
        @(posedge clk_ref);
        q.push_back('{acc, l, r});
        break;
      end
      @(posedge clk_ref);
      n++;
      if (n > 3 * FRAME) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout at cycle %0d: got no ready expected ready within %0d cycles", c, 3 * FRAME);
        break;
      end
      @(negedge clk_ref);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk_ref);
    sample_valid = 1'b0;
    repeat (n) @(negedge clk_ref);
  endtask

  initial begin
    logic [W-1:0] bl, br;
    int l0;

    repeat (10) @(negedge clk_ref);
    reset_n = 1'b1;

    offer(24'hABCDEF, 24'h123456);
    idle(5000);

    bl = W'($urandom);
    br = W'($urandom);
    for (int i = 0; i < 5; i++) offer(bl + W'(i), br + W'(i));
    idle(2 * FRAME);

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3000)) @(negedge clk_ref);
      offer(W'($urandom), W'($urandom));
      idle(1);
    end
    idle(2 * FRAME);

    l0 = FIRST + ((c - FIRST) / FRAME + 1) * FRAME;
    while (c < l0 + 1) @(negedge clk_ref);
    offer(W'($urandom), W'($urandom));
    idle(0);
    while (c < l0 + 60 * H + 3) @(negedge clk_ref);
    reset_n = 1'b0;
    @(posedge clk_ref);
    q.delete();
    repeat (4) @(negedge clk_ref);
    reset_n = 1'b1;
    idle(2 * FRAME + 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
